dmem_pipelined: RTL and testbench

Pipelined, parametrised RISC-V data memory that replaces the combinational-read data memory. It sits on the core's load/store port. It adds:
- a grant/response handshake;
- registered reads with configurable latency;
- an error response;
- optional hardware splitting of misaligned accesses into two word-bank operations.

Storage is word-organised with four byte lanes, little-endian.

---
 rtl/dmem_pipelined.sv | 211 +++++++++++++++++++++
 tb/tb_dmem_pipelined.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_pipelined.sv
// Word-banked RISC-V data memory with grant/response handshake and optional misaligned split.
// Latency: READ_LATENCY cycles for single-word accesses, one more for split accesses.
// Backpressure: dmem_gnt drops for one cycle while the second half of a split access runs.
package riscv_pkg;
  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b10
  } mem_size_t;
endpackage

module dmem_pipelined
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH       = 16,
  parameter int READ_LATENCY     = 1,
  parameter bit ALLOW_MISALIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_req,
  input  logic        dmem_wr_en,
  input  mem_size_t   dmem_data_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wr_data,
  input  logic        dmem_zero_extend,
  output logic        dmem_gnt,
  output logic        dmem_rvalid,
  output logic [31:0] dmem_rd_data,
  output logic        dmem_err
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int WORDS = 1 << IW;
  localparam logic [32:0] ADDR_MAX = 33'((64'd1 << ADDR_WIDTH) - 64'd1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SPLIT = 1'b1;

  logic [0:0] state;
  logic       in_split;

  // request decode
  logic [2:0]    span;
  logic [3:0]    base_be;
  logic          size_ok;
  logic [1:0]    lane;
  logic [IW-1:0] w_idx;
  logic          crossing;
  logic          hi_ok;
  logic [32:0]   last_addr;
  logic          req_err;
  logic          fire;
  logic          split_start;
  logic [7:0]    be8;
  logic [63:0]   dat64;

  always_comb begin
    span    = 3'd0;
    base_be = 4'b0000;
    size_ok = 1'b1;
    case (dmem_data_size)
      BYTE:      begin span = 3'd1; base_be = 4'b0001; end
      HALF_WORD: begin span = 3'd2; base_be = 4'b0011; end
      WORD:      begin span = 3'd4; base_be = 4'b1111; end
      default:   size_ok = 1'b0;
    endcase
  end

  assign lane        = dmem_addr[1:0];
  assign w_idx       = dmem_addr[ADDR_WIDTH-1:2];
  assign crossing    = ({1'b0, lane} + span) > 3'd4;
  assign hi_ok       = (dmem_addr >> ADDR_WIDTH) == 32'd0;
  assign last_addr   = {1'b0, dmem_addr} + {30'd0, span} - 33'd1;
  assign req_err     = !hi_ok || (last_addr > ADDR_MAX) || !size_ok ||
                       (crossing && !ALLOW_MISALIGNED);
  assign in_split    = (state == S_SPLIT);
  assign dmem_gnt    = rst_n && (state == S_IDLE);
  assign fire        = dmem_req && dmem_gnt;
  assign split_start = fire && !req_err && crossing;
  assign be8         = {4'd0, base_be} << lane;
  assign dat64       = {32'd0, dmem_wr_data} << {lane, 3'b000};

  // captured request for the second half of a split
  logic [IW-1:0] s_idx;
  logic [1:0]    s_lane;
  logic [31:0]   s_lo;
  mem_size_t     s_sz;
  logic          s_zx;
  logic          s_we;
  logic [3:0]    s_hi_be;
  logic [31:0]   s_hi_dat;

  logic [31:0]   mem [WORDS];
  logic [IW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic          wr_vld;
  logic [IW-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_dat;

  assign rd_idx  = in_split ? s_idx + 1'b1 : w_idx;
  assign rd_word = mem[rd_idx];

  always_comb begin
    wr_vld = 1'b0;
    wr_idx = w_idx;
    wr_be  = be8[3:0];
    wr_dat = dat64[31:0];
    if (in_split) begin
      wr_vld = s_we;
      wr_idx = s_idx + 1'b1;
      wr_be  = s_hi_be;
      wr_dat = s_hi_dat;
    end else if (fire && !req_err && dmem_wr_en) begin
      wr_vld = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      s_idx    <= '0;
      s_lane   <= 2'd0;
      s_lo     <= 32'd0;
      s_sz     <= BYTE;
      s_zx     <= 1'b0;
      s_we     <= 1'b0;
      s_hi_be  <= 4'd0;
      s_hi_dat <= 32'd0;
    end else if (state == S_IDLE) begin
      if (split_start) begin
        state    <= S_SPLIT;
        s_idx    <= w_idx;
        s_lane   <= lane;
        s_lo     <= rd_word;
        s_sz     <= dmem_data_size;
        s_zx     <= dmem_zero_extend;
        s_we     <= dmem_wr_en;
        s_hi_be  <= be8[7:4];
        s_hi_dat <= dat64[63:32];
      end
    end else begin
      state <= S_IDLE;
    end
  end

  function automatic logic [31:0] extend(input logic [31:0] v, input mem_size_t sz,
                                         input logic zx);
    case (sz)
      BYTE:      return zx ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      HALF_WORD: return zx ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default:   return v;
    endcase
  endfunction

  // split loads stitch the captured low word under the freshly read high word
  logic [63:0] ld_cat;
  logic [4:0]  ld_sh;
  logic [31:0] ld_word;
  logic        pin_vld;
  logic        pin_err;
  logic [31:0] pin_dat;
  logic        cur_we;

  assign ld_cat  = in_split ? {rd_word, s_lo} : {32'd0, rd_word};
  assign ld_sh   = in_split ? {s_lane, 3'b000} : {lane, 3'b000};
  assign ld_word = 32'(ld_cat >> ld_sh);
  assign cur_we  = in_split ? s_we : dmem_wr_en;
  assign pin_vld = in_split || (fire && (req_err || !crossing));
  assign pin_err = !in_split && req_err;
  assign pin_dat = (pin_err || cur_we) ? 32'd0 :
                   extend(ld_word, in_split ? s_sz : dmem_data_size,
                          in_split ? s_zx : dmem_zero_extend);

  logic        pv [READ_LATENCY];
  logic        pe [READ_LATENCY];
  logic [31:0] pd [READ_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pv[i] <= 1'b0;
        pe[i] <= 1'b0;
        pd[i] <= 32'd0;
      end
    end else begin
      pv[0] <= pin_vld;
      pe[0] <= pin_vld && pin_err;
      pd[0] <= pin_vld ? pin_dat : 32'd0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign dmem_rvalid  = pv[READ_LATENCY-1];
  assign dmem_err     = pe[READ_LATENCY-1];
  assign dmem_rd_data = pd[READ_LATENCY-1];

endmodule

// File: tb/tb_dmem_pipelined.sv
// Directed bench for dmem_pipelined: three instances cover split, fault and deep-latency configs.
// Each access is driven at negedge and its response sampled 1ns after the rising edge.
// Expected data and latencies are hand-computed constants.
module tb_dmem_pipelined;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req   [3];
  logic        we    [3];
  mem_size_t   sz    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdat  [3];
  logic        zext  [3];
  logic        gnt   [3];
  logic        rvalid[3];
  logic [31:0] rd_data[3];
  logic        err   [3];

  int checks = 0;
  int errors = 0;

  // u0: split enabled, latency 1; u1: misaligned faults; u2: latency 3
  dmem_pipelined #(.ADDR_WIDTH(16), .READ_LATENCY(1), .ALLOW_MISALIGNED(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .dmem_req(req[0]), .dmem_wr_en(we[0]),
    .dmem_data_size(sz[0]), .dmem_addr(addr[0]), .dmem_wr_data(wdat[0]),
    .dmem_zero_extend(zext[0]), .dmem_gnt(gnt[0]), .dmem_rvalid(rvalid[0]),
    .dmem_rd_data(rd_data[0]), .dmem_err(err[0]));

  dmem_pipelined #(.ADDR_WIDTH(16), .READ_LATENCY(1), .ALLOW_MISALIGNED(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .dmem_req(req[1]), .dmem_wr_en(we[1]),
    .dmem_data_size(sz[1]), .dmem_addr(addr[1]), .dmem_wr_data(wdat[1]),
    .dmem_zero_extend(zext[1]), .dmem_gnt(gnt[1]), .dmem_rvalid(rvalid[1]),
    .dmem_rd_data(rd_data[1]), .dmem_err(err[1]));

  dmem_pipelined #(.ADDR_WIDTH(16), .READ_LATENCY(3), .ALLOW_MISALIGNED(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .dmem_req(req[2]), .dmem_wr_en(we[2]),
    .dmem_data_size(sz[2]), .dmem_addr(addr[2]), .dmem_wr_data(wdat[2]),
    .dmem_zero_extend(zext[2]), .dmem_gnt(gnt[2]), .dmem_rvalid(rvalid[2]),
    .dmem_rd_data(rd_data[2]), .dmem_err(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input int d, input logic w, input mem_size_t s, input logic [31:0] a,
                        input logic [31:0] wd, input logic zx,
                        output logic [31:0] rdat, output logic rerr, output int lat,
                        output logic g_after);
    int wait_n;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; sz[d] = s; addr[d] = a; wdat[d] = wd; zext[d] = zx;
    wait_n = 0;
    while (!gnt[d] && wait_n < 8) begin
      @(negedge clk);
      wait_n++;
    end
    chk("gnt_wait", 32'(wait_n < 8), 32'd1);
    @(posedge clk);
    #1;
    req[d] = 1'b0;
    g_after = gnt[d];
    lat = 0;
    while (!rvalid[d] && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdat = rd_data[d];
    rerr = err[d];
    @(posedge clk);
    #1;
    chk("rvalid_pulse", 32'(rvalid[d]), 32'd0);
  endtask

  task automatic op(input string tag, input int d, input logic w, input mem_size_t s,
                    input logic [31:0] a, input logic [31:0] wd, input logic zx,
                    input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                    input logic exp_g);
    logic [31:0] r;
    logic        e;
    int          l;
    logic        g;
    access(d, w, s, a, wd, zx, r, e, l, g);
    chk({tag, ".data"}, r, exp_d);
    chk({tag, ".err"},  32'(e), 32'(exp_e));
    chk({tag, ".lat"},  32'(l), 32'(exp_lat));
    chk({tag, ".gnt"},  32'(g), 32'(exp_g));
  endtask

  logic [31:0] tp_exp [4];
  logic        seen;

  initial begin
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; sz[d] = WORD; addr[d] = 32'd0; wdat[d] = 32'd0;
      zext[d] = 1'b0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset.gnt",    32'(gnt[d]),    32'd0);
      chk("reset.rvalid", 32'(rvalid[d]), 32'd0);
      chk("reset.err",    32'(err[d]),    32'd0);
      chk("reset.rdata",  rd_data[d],     32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("release.gnt", 32'(gnt[d]), 32'd1);

    // aligned store/load and extension
    op("sw10",   0, 1'b1, WORD,      32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 0, 1'b1);
    op("lw10",   0, 1'b0, WORD,      32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 0, 1'b1);
    op("lb13",   0, 1'b0, BYTE,      32'h13, 32'h0,        1'b0, 32'hFFFFFFDE, 1'b0, 0, 1'b1);
    op("lhu12",  0, 1'b0, HALF_WORD, 32'h12, 32'h0,        1'b1, 32'h0000DEAD, 1'b0, 0, 1'b1);
    op("lh10",   0, 1'b0, HALF_WORD, 32'h10, 32'h0,        1'b0, 32'hFFFFBEEF, 1'b0, 0, 1'b1);
    op("lbu10",  0, 1'b0, BYTE,      32'h10, 32'h0,        1'b1, 32'h000000EF, 1'b0, 0, 1'b1);
    op("badsz",  0, 1'b0, mem_size_t'(2'b11), 32'h10, 32'h0, 1'b0, 32'h0,      1'b1, 0, 1'b1);

    // misaligned split
    op("sw20",   0, 1'b1, WORD,      32'h20, 32'h0,        1'b0, 32'h0,        1'b0, 0, 1'b1);
    op("sw24",   0, 1'b1, WORD,      32'h24, 32'h0,        1'b0, 32'h0,        1'b0, 0, 1'b1);
    op("sw21",   0, 1'b1, WORD,      32'h21, 32'h11223344, 1'b0, 32'h0,        1'b0, 1, 1'b0);
    op("lw20",   0, 1'b0, WORD,      32'h20, 32'h0,        1'b0, 32'h22334400, 1'b0, 0, 1'b1);
    op("lw24",   0, 1'b0, WORD,      32'h24, 32'h0,        1'b0, 32'h00000011, 1'b0, 0, 1'b1);
    op("lh23",   0, 1'b0, HALF_WORD, 32'h23, 32'h0,        1'b0, 32'h00001122, 1'b0, 1, 1'b0);
    op("lw22",   0, 1'b0, WORD,      32'h22, 32'h0,        1'b0, 32'h00112233, 1'b0, 1, 1'b0);

    // range errors
    op("lw10000", 0, 1'b0, WORD,     32'h00010000, 32'h0,  1'b0, 32'h0,        1'b1, 0, 1'b1);
    op("lwfffe",  0, 1'b0, WORD,     32'h0000FFFE, 32'h0,  1'b0, 32'h0,        1'b1, 0, 1'b1);

    // misaligned fault
    op("sw30",   1, 1'b1, WORD,      32'h30, 32'h55667788, 1'b0, 32'h0,        1'b0, 0, 1'b1);
    op("sh33",   1, 1'b1, HALF_WORD, 32'h33, 32'h0000AAAA, 1'b0, 32'h0,        1'b1, 0, 1'b1);
    op("lw30",   1, 1'b0, WORD,      32'h30, 32'h0,        1'b0, 32'h55667788, 1'b0, 0, 1'b1);

    // latency 3 throughput
    for (int k = 0; k < 4; k++) begin
      tp_exp[k] = 32'hA0000001 + 32'(k) * 32'h01010101;
      op("tp_sw", 2, 1'b1, WORD, 32'h40 + 32'(4 * k), tp_exp[k], 1'b0, 32'h0, 1'b0, 2, 1'b1);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 4) begin
        req[2] = 1'b1; we[2] = 1'b0; sz[2] = WORD; addr[2] = 32'h40 + 32'(4 * k);
        chk("tp.gnt", 32'(gnt[2]), 32'd1);
      end else begin
        req[2] = 1'b0;
      end
      @(posedge clk);
      #1;
      if (k >= 2 && k <= 5) begin
        chk("tp.rvalid", 32'(rvalid[2]), 32'd1);
        chk("tp.data",   rd_data[2],     tp_exp[k-2]);
      end else begin
        chk("tp.idle",   32'(rvalid[2]), 32'd0);
      end
    end

    // reset in the middle of a split store
    op("sw50",   0, 1'b1, WORD,      32'h50, 32'h0,        1'b0, 32'h0,        1'b0, 0, 1'b1);
    op("sw54",   0, 1'b1, WORD,      32'h54, 32'h0,        1'b0, 32'h0,        1'b0, 0, 1'b1);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; sz[0] = WORD; addr[0] = 32'h52; wdat[0] = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    chk("rsplit.in_split", 32'(gnt[0]), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rsplit.rvalid", 32'(rvalid[0]), 32'd0);
    chk("rsplit.err",    32'(err[0]),    32'd0);
    chk("rsplit.rdata",  rd_data[0],     32'd0);
    chk("rsplit.gnt",    32'(gnt[0]),    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      seen = seen | rvalid[0];
    end
    chk("rsplit.no_rsp", 32'(seen), 32'd0);
    op("lw50",   0, 1'b0, WORD,      32'h50, 32'h0,        1'b0, 32'hF00D0000, 1'b0, 0, 1'b1);
    op("lw54",   0, 1'b0, WORD,      32'h54, 32'h0,        1'b0, 32'h00000000, 1'b0, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
